// File: rtl/char_seq_pkg.sv
// ---------------------------------------------------------------------------
// char_seq_pkg
// Shared types and default geometry for the character sprite sequencer.
//   act_t        : fighter action / animation state, numerically equal to the
//                  action request code (0 idle, 1 walk, 2 attack, 3 hurt)
//   DEF_*        : default sprite geometry and animation timing
//   FRAME_PIXELS : pixels in one stored animation frame
//   ctrWidth()   : bit width for a counter that must hold 0..n-1
// ---------------------------------------------------------------------------
package char_seq_pkg;

    typedef enum logic [1:0] {
        ACT_IDLE   = 2'd0,
        ACT_WALK   = 2'd1,
        ACT_ATTACK = 2'd2,
        ACT_HURT   = 2'd3
    } act_t;

    localparam int DEF_SPRITE_W       = 41;
    localparam int DEF_SPRITE_H       = 65;
    localparam int DEF_FRAMES         = 4;
    localparam int DEF_TICKS_PER_STEP = 6;
    localparam int DEF_ADDR_W         = 16;

    localparam int FRAME_PIXELS = DEF_SPRITE_W * DEF_SPRITE_H;

    // Width needed to count 0..n-1, never narrower than one bit so that a
    // single-frame or single-tick configuration still elaborates.
    function automatic int ctrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/char_anim_fsm.sv
// ---------------------------------------------------------------------------
// char_anim_fsm
// Animation state machine for one fighter. IDLE and WALK loop forever;
// ATTACK and HURT play once and then fall back to IDLE.
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous, active-high
//   tick_i     in   one-cycle animation tick (rising edge of frame_clk)
//   act_req_i  in   requested action
//   state_o    out  current action (registered)
//   step_o     out  current animation frame within the action (registered)
//   busy_o     out  high while an ATTACK or HURT one-shot is playing
// ---------------------------------------------------------------------------
module char_anim_fsm
    import char_seq_pkg::*;
#(
    parameter int FRAMES         = DEF_FRAMES,
    parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP,
    parameter int STEP_W         = ctrWidth(DEF_FRAMES),
    parameter int TICK_W         = ctrWidth(DEF_TICKS_PER_STEP)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              tick_i,
    input  act_t              act_req_i,
    output act_t              state_o,
    output logic [STEP_W-1:0] step_o,
    output logic              busy_o
);

    act_t              state_q;
    logic [STEP_W-1:0] step_q;
    logic [TICK_W-1:0] tickCnt_q;
    logic              busy_q;

    logic stepDone;
    logic lastStep;

    // A tick that lands on the last count of a step finishes that step;
    // finishing the last step of a one-shot ends the action.
    assign stepDone = (tickCnt_q == TICK_W'(TICKS_PER_STEP - 1));
    assign lastStep = (step_q == STEP_W'(FRAMES - 1));

    // Whole animation controller in one registered block. An accepted action
    // change always restarts the animation and swallows any tick arriving in
    // the same cycle. busy is derived from the next state so it moves in the
    // same cycle as the state it describes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ACT_IDLE;
            step_q    <= '0;
            tickCnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ACT_IDLE, ACT_WALK: begin
                    if (act_req_i != state_q) begin
                        state_q   <= act_req_i;
                        step_q    <= '0;
                        tickCnt_q <= '0;
                        busy_q    <= (act_req_i == ACT_ATTACK) || (act_req_i == ACT_HURT);
                    end else if (tick_i) begin
                        if (stepDone) begin
                            tickCnt_q <= '0;
                            step_q    <= lastStep ? '0 : step_q + STEP_W'(1);
                        end else begin
                            tickCnt_q <= tickCnt_q + TICK_W'(1);
                        end
                    end
                end
                ACT_ATTACK, ACT_HURT: begin
                    if ((state_q == ACT_ATTACK) && (act_req_i == ACT_HURT)) begin
                        state_q   <= ACT_HURT;
                        step_q    <= '0;
                        tickCnt_q <= '0;
                        busy_q    <= 1'b1;
                    end else if (tick_i) begin
                        if (stepDone) begin
                            tickCnt_q <= '0;
                            if (lastStep) begin
                                state_q <= ACT_IDLE;
                                step_q  <= '0;
                                busy_q  <= 1'b0;
                            end else begin
                                step_q <= step_q + STEP_W'(1);
                            end
                        end else begin
                            tickCnt_q <= tickCnt_q + TICK_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign step_o  = step_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/char_sprite_sequencer.sv
// ---------------------------------------------------------------------------
// char_sprite_sequencer
// Drives the shared character frame ROM for the player and the NPC. Each
// fighter has its own animation FSM; the current scan pixel is turned into a
// ROM address plus an in-box flag, both registered one cycle after the
// pixel is presented.
// Ports:
//   Clk, Reset                  clock, synchronous active-high reset
//   frame_clk                   per-frame strobe, each rising edge is a tick
//   DrawX, DrawY                current scan pixel
//   player_x/_y, npc_x/_y       sprite top-left corners
//   player_face_l, npc_face_l   1 = sprite mirrored horizontally
//   player_act_req, npc_act_req requested action (0 idle,1 walk,2 attack,3 hurt)
//   Player_address, NPC_address ROM addresses (0 when outside the box)
//   player_in_box, npc_in_box   pixel lies inside the sprite box
//   player_busy, npc_busy       attack or hurt one-shot in progress
// ---------------------------------------------------------------------------
module char_sprite_sequencer
    import char_seq_pkg::*;
#(
    parameter int SPRITE_W       = DEF_SPRITE_W,
    parameter int SPRITE_H       = DEF_SPRITE_H,
    parameter int FRAMES         = DEF_FRAMES,
    parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        player_x,
    input  logic [9:0]        player_y,
    input  logic [9:0]        npc_x,
    input  logic [9:0]        npc_y,
    input  logic              player_face_l,
    input  logic              npc_face_l,
    input  logic [1:0]        player_act_req,
    input  logic [1:0]        npc_act_req,
    output logic [ADDR_W-1:0] Player_address,
    output logic [ADDR_W-1:0] NPC_address,
    output logic              player_in_box,
    output logic              npc_in_box,
    output logic              player_busy,
    output logic              npc_busy
);

    localparam int STEP_W    = ctrWidth(FRAMES);
    localparam int TICK_W    = ctrWidth(TICKS_PER_STEP);
    localparam int FRAME_PIX = SPRITE_W * SPRITE_H;

    // The box test runs at 11 bits so a sprite whose right or bottom edge
    // passes 1023 cannot wrap around and claim pixels at the screen start.
    function automatic logic inBox(input logic [9:0] drawX, input logic [9:0] drawY,
                                   input logic [9:0] posX,  input logic [9:0] posY);
        logic [10:0] dX;
        logic [10:0] dY;
        logic [10:0] pX;
        logic [10:0] pY;
        dX = {1'b0, drawX};
        dY = {1'b0, drawY};
        pX = {1'b0, posX};
        pY = {1'b0, posY};
        return (dX >= pX) && (dX < pX + 11'(SPRITE_W)) &&
               (dY >= pY) && (dY < pY + 11'(SPRITE_H));
    endfunction

    // ROM layout is action-major: frame (act*FRAMES + step), then rows of
    // SPRITE_W pixels. Mirroring just reads each row right to left.
    function automatic logic [ADDR_W-1:0] spriteAddr(
        input logic [9:0]        drawX, input logic [9:0] drawY,
        input logic [9:0]        posX,  input logic [9:0] posY,
        input logic              faceL,
        input act_t              act,
        input logic [STEP_W-1:0] step);
        logic [9:0] dx;
        logic [9:0] dy;
        logic [9:0] col;
        dx  = drawX - posX;
        dy  = drawY - posY;
        col = faceL ? (10'(SPRITE_W - 1) - dx) : dx;
        return ADDR_W'((32'(act) * 32'(FRAMES) + 32'(step)) * 32'(FRAME_PIX) +
                       32'(dy) * 32'(SPRITE_W) + 32'(col));
    endfunction

    logic frameClk_q;
    logic tick;

    act_t              playerState;
    act_t              npcState;
    logic [STEP_W-1:0] playerStep;
    logic [STEP_W-1:0] npcStep;

    logic              playerBox_d;
    logic              npcBox_d;
    logic [ADDR_W-1:0] playerAddr_d;
    logic [ADDR_W-1:0] npcAddr_d;
    logic              playerBox_q;
    logic              npcBox_q;
    logic [ADDR_W-1:0] playerAddr_q;
    logic [ADDR_W-1:0] npcAddr_q;

    // Remember last cycle's frame_clk so a rising edge becomes a single
    // one-cycle tick no matter how long frame_clk stays high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frameClk_q <= 1'b0;
        end else begin
            frameClk_q <= frame_clk;
        end
    end

    assign tick = frame_clk & ~frameClk_q;

    char_anim_fsm #(
        .FRAMES         (FRAMES),
        .TICKS_PER_STEP (TICKS_PER_STEP),
        .STEP_W         (STEP_W),
        .TICK_W         (TICK_W)
    ) u_player_fsm (
        .Clk       (Clk),
        .Reset     (Reset),
        .tick_i    (tick),
        .act_req_i (act_t'(player_act_req)),
        .state_o   (playerState),
        .step_o    (playerStep),
        .busy_o    (player_busy)
    );

    char_anim_fsm #(
        .FRAMES         (FRAMES),
        .TICKS_PER_STEP (TICKS_PER_STEP),
        .STEP_W         (STEP_W),
        .TICK_W         (TICK_W)
    ) u_npc_fsm (
        .Clk       (Clk),
        .Reset     (Reset),
        .tick_i    (tick),
        .act_req_i (act_t'(npc_act_req)),
        .state_o   (npcState),
        .step_o    (npcStep),
        .busy_o    (npc_busy)
    );

    // Address generation for the pixel presented this cycle, using the
    // animation frame currently held by each FSM. Outside the box the address
    // is forced to 0, the transparent ROM entry.
    always_comb begin
        playerBox_d  = inBox(DrawX, DrawY, player_x, player_y);
        npcBox_d     = inBox(DrawX, DrawY, npc_x, npc_y);
        playerAddr_d = '0;
        npcAddr_d    = '0;
        if (playerBox_d) begin
            playerAddr_d = spriteAddr(DrawX, DrawY, player_x, player_y,
                                      player_face_l, playerState, playerStep);
        end
        if (npcBox_d) begin
            npcAddr_d = spriteAddr(DrawX, DrawY, npc_x, npc_y,
                                   npc_face_l, npcState, npcStep);
        end
    end

    // One pipeline stage so address and in-box flag reach the ROM together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            playerBox_q  <= 1'b0;
            npcBox_q     <= 1'b0;
            playerAddr_q <= '0;
            npcAddr_q    <= '0;
        end else begin
            playerBox_q  <= playerBox_d;
            npcBox_q     <= npcBox_d;
            playerAddr_q <= playerAddr_d;
            npcAddr_q    <= npcAddr_d;
        end
    end

    assign Player_address = playerAddr_q;
    assign NPC_address    = npcAddr_q;
    assign player_in_box  = playerBox_q;
    assign npc_in_box     = npcBox_q;

endmodule
